gshare_predictor: RTL
=====================

Name: gshare_predictor

Overview:
- Gshare branch direction predictor answering fetch-stage prediction queries and absorbing execute-stage resolution and training.
- Query side: fetch presents a branch PC and receives a combinational taken/not-taken prediction plus the table index and history snapshot, which travel down the pipe.
- Resolve side: EX returns index, snapshot, predicted and actual direction. The block trains its 2-bit counters and repairs the speculative global history on a misprediction.

Parameters:
- HIST_W, 3, global history width = table index width; table depth 2^HIST_W.
- PC_W, 10, instruction address width.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- Branch_F  input  1  fetch holds a conditional branch (beq/bne) this cycle.
- hold  input  1  fetch stalled; same PC re-presented next cycle.
- brn_pc  input  PC_W  PC of fetched branch.
- prediction  output  1  predicted direction, 1 = taken.
- state_index  output  HIST_W  table index used for this prediction.
- hist_F  output  HIST_W  GHR value before this branch's speculative shift.
- Branch_EX  input  1  branch resolving in EX this cycle.
- taken  input  1  actual direction of EX branch.
- prediction_EX  input  1  direction predicted for EX branch.
- prev_idx  input  HIST_W  state_index carried to EX.
- hist_EX  input  HIST_W  hist_F carried to EX.
- mispredict  output  1  Branch_EX & (prediction_EX ^ taken), combinational.

Behaviour:
- Storage: GHR register (HIST_W bits); counter array ctr[0 .. 2^HIST_W-1], 2 bits each.
- Reset (rst=0, async): GHR=0, every ctr=2'b01 (weakly not-taken). Outputs follow combinationally, so prediction=0, state_index=brn_pc[HIST_W-1:0], hist_F=0, mispredict per inputs.
- Index: state_index = brn_pc[HIST_W-1:0] ^ GHR.
- Prediction: prediction = ctr[state_index][1], zero latency. No write-to-read bypass: a same-cycle EX update to the same entry is seen the next cycle.
- hist_F = GHR (pre-shift).
- Training, clock edge when Branch_EX=1:
  - taken=1: ctr[prev_idx] saturating increment, max 2'b11.
  - taken=0: ctr[prev_idx] saturating decrement, min 2'b00.
  - Trained independently of the GHR priority below.
- GHR update priority, one per edge:
  1. mispredict=1: GHR <= {hist_EX[HIST_W-2:0], taken} (repair to true path). Any same-cycle fetch branch is on the wrong path and is dropped.
  2. Else Branch_F=1 and hold=0: GHR <= {GHR[HIST_W-2:0], prediction} (speculative shift).
  3. Else hold.
- hold=1 with Branch_F=1: no GHR shift, so the re-presented branch gets the identical index.
- Correctly predicted EX branches leave the GHR untouched (already shifted speculatively).
- Reset mid-operation: immediate return to reset state; in-flight EX data is ignored until rst=1.
- Inputs X while Branch_F/Branch_EX are 0 must not corrupt state.

Optional Feature:
- Macro: BPU_STATS_EN.
- Defined: adds outputs br_count[15:0] and mp_count[15:0].
  - br_count increments on each edge with Branch_EX=1.
  - mp_count increments on each edge with mispredict=1.
  - Both saturate at 16'hFFFF and reset to 0 on rst=0.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset: drive rst=0 then release; brn_pc=10'h005, Branch_F=1 -> state_index=3'h5, hist_F=0, prediction=0. Next edge GHR=3'b000 (shifted-in 0).
- Training: Branch_EX=1, taken=1, prev_idx=2, two cycles -> ctr[2] 01→10→11. Query with brn_pc=10'h002, GHR=0 -> prediction=1. Third taken stays 11. Four not-taken -> 00, stays 00.
- Speculative shift: ctr all 11, GHR=0, three consecutive Branch_F=1 -> GHR 001, 011, 111. Same sequence with hold=1 -> GHR stays 000.
- Misprediction repair: GHR=3'b111, Branch_EX=1, prediction_EX=1, taken=0, hist_EX=3'b011, Branch_F=1 same cycle -> mispredict=1, next GHR=3'b110, fetch shift dropped.
- Collision: same cycle EX trains index 4 from 01 to 10 while fetch queries index 4 -> prediction=0 this cycle, 1 next cycle.
- BPU_STATS_EN: 5 resolved branches, 2 mispredicted -> br_count=5, mp_count=2. Assert rst=0 mid-run -> both 0 immediately.

Source files
------------

// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor
// Description : Gshare branch direction predictor. Fetch side indexes a table
//               of 2-bit saturating counters with PC ^ GHR and returns a
//               combinational prediction; EX side trains the counters and
//               repairs the speculative global history on a misprediction.
//               Optional statistics counters are enabled with the macro
//               BPU_STATS_EN (adds br_count / mp_count outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_predictor #(
    parameter int HIST_W = 3,
    parameter int PC_W   = 10
) (
    input  logic              clk,
    input  logic              rst,            // asynchronous, active low
    // fetch-side query
    input  logic              Branch_F,
    input  logic              hold,
    input  logic [PC_W-1:0]   brn_pc,
    output logic              prediction,
    output logic [HIST_W-1:0] state_index,
    output logic [HIST_W-1:0] hist_F,
    // execute-side resolution
    input  logic              Branch_EX,
    input  logic              taken,
    input  logic              prediction_EX,
    input  logic [HIST_W-1:0] prev_idx,
    input  logic [HIST_W-1:0] hist_EX,
`ifdef BPU_STATS_EN
    output logic [15:0]       br_count,
    output logic [15:0]       mp_count,
`endif
    output logic              mispredict
);

    localparam int c_DEPTH = 1 << HIST_W;

    logic [HIST_W-1:0] r_ghr;
    logic [1:0]        r_ctr [c_DEPTH];

    // Only the low PC bits take part in the hash.
    logic w_unused_pc;
    assign w_unused_pc = &{1'b0, brn_pc[PC_W-1:HIST_W]};

    // Query path: purely combinational, no bypass from a same-cycle update.
    assign state_index = brn_pc[HIST_W-1:0] ^ r_ghr;
    assign prediction  = r_ctr[state_index][1];
    assign hist_F      = r_ghr;
    assign mispredict  = Branch_EX & (prediction_EX ^ taken);

    // One saturating counter per table entry, trained when EX resolves to it.
    generate
        for (genvar i = 0; i < c_DEPTH; i++) begin : g_ctr
            localparam logic [HIST_W-1:0] c_IDX = HIST_W'(i);
            // Train this entry toward the resolved direction.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_ctr[i] <= 2'b01;
                end else if (Branch_EX && (prev_idx == c_IDX)) begin
                    if (taken) begin
                        if (r_ctr[i] != 2'b11) r_ctr[i] <= r_ctr[i] + 2'd1;
                    end else begin
                        if (r_ctr[i] != 2'b00) r_ctr[i] <= r_ctr[i] - 2'd1;
                    end
                end
            end
        end
    endgenerate

    // GHR: repair on mispredict wins over the (wrong-path) speculative shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ghr <= '0;
        end else if (mispredict) begin
            r_ghr <= {hist_EX[HIST_W-2:0], taken};
        end else if (Branch_F && !hold) begin
            r_ghr <= {r_ghr[HIST_W-2:0], prediction};
        end
    end

`ifdef BPU_STATS_EN
    logic [15:0] r_br_count;
    logic [15:0] r_mp_count;

    // Saturating count of resolved branches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_br_count <= '0;
        end else if (Branch_EX && (r_br_count != 16'hFFFF)) begin
            r_br_count <= r_br_count + 16'd1;
        end
    end

    // Saturating count of mispredicted branches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mp_count <= '0;
        end else if (mispredict && (r_mp_count != 16'hFFFF)) begin
            r_mp_count <= r_mp_count + 16'd1;
        end
    end

    assign br_count = r_br_count;
    assign mp_count = r_mp_count;
`endif

endmodule
`default_nettype wire
